// File: rtl/w_bank_loader.sv
// Kernel-weight bank: 16 lanes x 16 entries of signed bytes, filled lane-inner from a valid/ready stream,
// 1-cycle registered reads per lane while READY, zero otherwise; W_BANK_CHECKSUM_EN adds a load checksum.
module w_bank_loader #(
    parameter int LANES = 16,
    parameter int DEPTH = 16,
    parameter int AW    = 4,
    parameter int DW    = 8
) (
    input  logic                 clk,
    input  logic                 xrst,
    input  logic                 load_start,
    input  logic                 in_valid,
    input  logic signed [DW-1:0] in_data,
    output logic                 in_ready,
    output logic                 busy,
    output logic                 bank_ready,
    output logic                 load_done,
    input  logic [AW-1:0]        w0_raddr,
    input  logic [AW-1:0]        w1_raddr,
    input  logic [AW-1:0]        w2_raddr,
    input  logic [AW-1:0]        w3_raddr,
    input  logic [AW-1:0]        w4_raddr,
    input  logic [AW-1:0]        w5_raddr,
    input  logic [AW-1:0]        w6_raddr,
    input  logic [AW-1:0]        w7_raddr,
    input  logic [AW-1:0]        w8_raddr,
    input  logic [AW-1:0]        w9_raddr,
    input  logic [AW-1:0]        w10_raddr,
    input  logic [AW-1:0]        w11_raddr,
    input  logic [AW-1:0]        w12_raddr,
    input  logic [AW-1:0]        w13_raddr,
    input  logic [AW-1:0]        w14_raddr,
    input  logic [AW-1:0]        w15_raddr,
    output logic signed [DW-1:0] w0_rdata,
    output logic signed [DW-1:0] w1_rdata,
    output logic signed [DW-1:0] w2_rdata,
    output logic signed [DW-1:0] w3_rdata,
    output logic signed [DW-1:0] w4_rdata,
    output logic signed [DW-1:0] w5_rdata,
    output logic signed [DW-1:0] w6_rdata,
    output logic signed [DW-1:0] w7_rdata,
    output logic signed [DW-1:0] w8_rdata,
    output logic signed [DW-1:0] w9_rdata,
    output logic signed [DW-1:0] w10_rdata,
    output logic signed [DW-1:0] w11_rdata,
    output logic signed [DW-1:0] w12_rdata,
    output logic signed [DW-1:0] w13_rdata,
    output logic signed [DW-1:0] w14_rdata,
    output logic signed [DW-1:0] w15_rdata
`ifdef W_BANK_CHECKSUM_EN
    ,
    output logic [15:0]          checksum
`endif
);

    localparam int LW = $clog2(LANES);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_READY} state_t;

    state_t               state;
    logic [LW-1:0]        lane_cnt;
    logic [AW-1:0]        addr_cnt;
    logic signed [DW-1:0] mem   [LANES][DEPTH];
    logic [AW-1:0]        raddr [LANES];
    logic signed [DW-1:0] rdata [LANES];
    logic                 beat;
    logic                 last_beat;

    assign raddr[0]  = w0_raddr;
    assign raddr[1]  = w1_raddr;
    assign raddr[2]  = w2_raddr;
    assign raddr[3]  = w3_raddr;
    assign raddr[4]  = w4_raddr;
    assign raddr[5]  = w5_raddr;
    assign raddr[6]  = w6_raddr;
    assign raddr[7]  = w7_raddr;
    assign raddr[8]  = w8_raddr;
    assign raddr[9]  = w9_raddr;
    assign raddr[10] = w10_raddr;
    assign raddr[11] = w11_raddr;
    assign raddr[12] = w12_raddr;
    assign raddr[13] = w13_raddr;
    assign raddr[14] = w14_raddr;
    assign raddr[15] = w15_raddr;

    assign w0_rdata  = rdata[0];
    assign w1_rdata  = rdata[1];
    assign w2_rdata  = rdata[2];
    assign w3_rdata  = rdata[3];
    assign w4_rdata  = rdata[4];
    assign w5_rdata  = rdata[5];
    assign w6_rdata  = rdata[6];
    assign w7_rdata  = rdata[7];
    assign w8_rdata  = rdata[8];
    assign w9_rdata  = rdata[9];
    assign w10_rdata = rdata[10];
    assign w11_rdata = rdata[11];
    assign w12_rdata = rdata[12];
    assign w13_rdata = rdata[13];
    assign w14_rdata = rdata[14];
    assign w15_rdata = rdata[15];

    // in_ready is high exactly while in LOAD, so a beat can only land in that state.
    assign beat      = in_valid & in_ready;
    assign last_beat = beat && (lane_cnt == LW'(LANES - 1)) && (addr_cnt == AW'(DEPTH - 1));

    always_ff @(posedge clk or negedge xrst) begin
        if (!xrst) begin
            state      <= S_IDLE;
            in_ready   <= 1'b0;
            busy       <= 1'b0;
            bank_ready <= 1'b0;
            load_done  <= 1'b0;
            lane_cnt   <= '0;
            addr_cnt   <= '0;
        end else begin
            load_done <= 1'b0;
            case (state)
                S_IDLE, S_READY: begin
                    if (load_start) begin
                        state      <= S_LOAD;
                        in_ready   <= 1'b1;
                        busy       <= 1'b1;
                        bank_ready <= 1'b0;
                        lane_cnt   <= '0;
                        addr_cnt   <= '0;
                    end
                end
                S_LOAD: begin
                    // load_start is deliberately not looked at here: a load never restarts.
                    if (beat) begin
                        if (last_beat) begin
                            state      <= S_READY;
                            in_ready   <= 1'b0;
                            busy       <= 1'b0;
                            bank_ready <= 1'b1;
                            load_done  <= 1'b1;
                        end
                        if (lane_cnt == LW'(LANES - 1)) begin
                            lane_cnt <= '0;
                            addr_cnt <= addr_cnt + AW'(1);
                        end else begin
                            lane_cnt <= lane_cnt + LW'(1);
                        end
                    end
                end
                default: begin
                    state    <= S_IDLE;
                    in_ready <= 1'b0;
                    busy     <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (beat) begin
            mem[lane_cnt][addr_cnt] <= in_data;
        end
    end

    // Reads are zeroed from the edge that leaves READY, so a reload never exposes stale data.
    always_ff @(posedge clk or negedge xrst) begin
        if (!xrst) begin
            for (int i = 0; i < LANES; i++) begin
                rdata[i] <= '0;
            end
        end else begin
            for (int i = 0; i < LANES; i++) begin
                rdata[i] <= (state == S_READY && !load_start) ? mem[i][raddr[i]] : '0;
            end
        end
    end

`ifdef W_BANK_CHECKSUM_EN
    always_ff @(posedge clk or negedge xrst) begin
        if (!xrst) begin
            checksum <= '0;
        end else if (load_start && (state == S_IDLE || state == S_READY)) begin
            checksum <= '0;
        end else if (beat) begin
            checksum <= checksum + {{(16 - DW){in_data[DW-1]}}, in_data};
        end
    end
`endif

endmodule

// File: tb/tb_w_bank_loader.sv
// Directed/randomised bench for w_bank_loader with a byte-array reference of the bank contents.
module tb_w_bank_loader;

    logic       clk = 1'b0;
    logic       xrst = 1'b0;
    logic       load_start = 1'b0;
    logic       in_valid = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       in_ready, busy, bank_ready, load_done;
    logic [3:0] ra [16];
    logic [7:0] rd [16];
`ifdef W_BANK_CHECKSUM_EN
    logic [15:0] checksum;
`endif

    logic [7:0]  model [16][16];
    logic [15:0] csum_model;
    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    w_bank_loader dut (
        .clk(clk), .xrst(xrst), .load_start(load_start), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .busy(busy), .bank_ready(bank_ready), .load_done(load_done),
        .w0_raddr(ra[0]), .w1_raddr(ra[1]), .w2_raddr(ra[2]), .w3_raddr(ra[3]),
        .w4_raddr(ra[4]), .w5_raddr(ra[5]), .w6_raddr(ra[6]), .w7_raddr(ra[7]),
        .w8_raddr(ra[8]), .w9_raddr(ra[9]), .w10_raddr(ra[10]), .w11_raddr(ra[11]),
        .w12_raddr(ra[12]), .w13_raddr(ra[13]), .w14_raddr(ra[14]), .w15_raddr(ra[15]),
        .w0_rdata(rd[0]), .w1_rdata(rd[1]), .w2_rdata(rd[2]), .w3_rdata(rd[3]),
        .w4_rdata(rd[4]), .w5_rdata(rd[5]), .w6_rdata(rd[6]), .w7_rdata(rd[7]),
        .w8_rdata(rd[8]), .w9_rdata(rd[9]), .w10_rdata(rd[10]), .w11_rdata(rd[11]),
        .w12_rdata(rd[12]), .w13_rdata(rd[13]), .w14_rdata(rd[14]), .w15_rdata(rd[15])
`ifdef W_BANK_CHECKSUM_EN
        , .checksum(checksum)
`endif
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] gen(input int pat, input int b);
        logic [7:0] v;
        v = b[7:0];
        case (pat)
            0:       return v;
            1:       return ~v;
            2:       return 8'hFF;
            default: return 8'($urandom);
        endcase
    endfunction

    // Full load: beat b goes to lane b%16, address b/16; cycles counts edges from load_start on.
    task automatic do_load(input int pat, input bit stall, input bit glitch, input int exp_cycles);
        int beats = 0;
        int cycles;
        bit v, acc;
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
        cycles = 1;
        csum_model = 16'h0;
        chk("start_busy", busy, 1);
        chk("start_in_ready", in_ready, 1);
        chk("start_bank_ready", bank_ready, 0);
        chk("start_rd0_zero", rd[0], 0);
        while (beats < 256 && cycles < 3000) begin
            v = stall ? (cycles % 2 == 1) : 1'b1;
            in_valid = v;
            in_data = gen(pat, beats);
            load_start = glitch && (beats == 50 || beats == 255);
            acc = v && in_ready;
            tick();
            cycles++;
            if (acc) begin
                model[beats % 16][beats / 16] = in_data;
                csum_model = csum_model + {{8{in_data[7]}}, in_data};
                beats++;
            end
        end
        in_valid = 1'b0;
        load_start = 1'b0;
        chk("load_cycles", cycles, exp_cycles);
        chk("load_done_pulse", load_done, 1);
        chk("ready_after_load", bank_ready, 1);
        chk("in_ready_after_load", in_ready, 0);
`ifdef W_BANK_CHECKSUM_EN
        chk("checksum", checksum, csum_model);
`endif
        tick();
        chk("load_done_one_cycle", load_done, 0);
        chk("ready_held", bank_ready, 1);
    endtask

    task automatic read_burst(input int n);
        logic [3:0] prev [16];
        for (int c = 0; c < n; c++) begin
            for (int l = 0; l < 16; l++) begin
                ra[l] = 4'($urandom);
                prev[l] = ra[l];
            end
            tick();
            for (int l = 0; l < 16; l++)
                chk($sformatf("burst_l%0d_a%0d", l, prev[l]), rd[l], model[l][prev[l]]);
        end
    endtask

    initial begin
        for (int l = 0; l < 16; l++) ra[l] = 4'h0;
        repeat (3) tick();
        xrst = 1'b1;
        tick();
        for (int l = 0; l < 16; l++) chk($sformatf("reset_rd%0d", l), rd[l], 0);
        chk("reset_bank_ready", bank_ready, 0);
        chk("reset_in_ready", in_ready, 0);
        chk("reset_busy", busy, 0);
        chk("reset_load_done", load_done, 0);

        do_load(0, 1'b0, 1'b1, 257);
        ra[7] = 4'd3;
        tick();
        chk("w7_addr3", rd[7], 8'h37);
        read_burst(20);

        do_load(1, 1'b0, 1'b0, 257);
        ra[0] = 4'd0;
        tick();
        chk("inverted_w0_addr0", rd[0], 8'hFF);
        read_burst(10);

        do_load(2, 1'b1, 1'b0, 512);
        for (int a = 0; a < 16; a++) begin
            for (int l = 0; l < 16; l++) ra[l] = 4'(a);
            tick();
            for (int l = 0; l < 16; l++) chk($sformatf("minus1_l%0d_a%0d", l, a), rd[l], 8'hFF);
        end
`ifdef W_BANK_CHECKSUM_EN
        chk("checksum_minus256", checksum, 16'hFF00);
`endif

        do_load(3, 1'b0, 1'b0, 257);
        read_burst(20);

        load_start = 1'b1;
        tick();
        load_start = 1'b0;
        for (int b = 0; b < 100; b++) begin
            in_valid = 1'b1;
            in_data = 8'($urandom);
            tick();
        end
        in_valid = 1'b0;
        xrst = 1'b0;
        #1;
        chk("midreset_in_ready", in_ready, 0);
        chk("midreset_bank_ready", bank_ready, 0);
        chk("midreset_busy", busy, 0);
        chk("midreset_rd3", rd[3], 0);
        tick();
        tick();
        xrst = 1'b1;
        tick();
        chk("after_reset_idle_ready", bank_ready, 0);
        chk("after_reset_idle_in_ready", in_ready, 0);
        do_load(3, 1'b0, 1'b0, 257);
        read_burst(10);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/w_bank_loader.md
Name: w_bank_loader

Overview:
- Kernel-weight storage bank, the serving end of the per-PE weight read interface (16 lanes, 4-bit raddr, signed 8-bit rdata).
- Loaded from a byte stream via a valid/ready handshake.
- Once loaded, serves 16 independent read ports with fixed 1-cycle latency to the convolution PE array.
- A small state machine sequences the load and flags bank readiness.

Parameters:
- LANES, 16, number of read lanes / banks.
- DEPTH, 16, entries per lane.
- AW, 4, address width (log2 DEPTH).
- DW, 8, weight width (signed).

Ports:
- clk  input  1  clock, rising edge.
- xrst  input  1  reset; asynchronous, active-low.
- load_start  input  1  one-cycle pulse; begins a full bank load.
- in_valid  input  1  load stream beat valid.
- in_data  input  DW  signed weight byte.
- in_ready  output  1  bank accepts a beat this cycle.
- busy  output  1  high while loading.
- bank_ready  output  1  bank holds a complete kernel; reads valid.
- load_done  output  1  one-cycle pulse after the final beat is written.
- wN_raddr  input  AW  read address, lane N (N=0..LANES-1, 16 ports).
- wN_rdata  output  DW  signed read data, lane N (16 ports).
- checksum  output  16  only with W_BANK_CHECKSUM_EN (see below).

Behaviour:
- Reset (xrst low, async):
  - state=IDLE; in_ready=0, busy=0, bank_ready=0, load_done=0.
  - All wN_rdata=0; lane counter=0, address counter=0.
  - Storage array is not reset; contents are undefined until loaded.
- States: IDLE, LOAD, READY.
- IDLE: load_start=1 -> LOAD; counters cleared.
- LOAD:
  - in_ready=1, busy=1, bank_ready=0.
  - A beat transfers when in_valid&in_ready; in_data is written to lane[lane_cnt][addr_cnt] at that edge.
  - Order is lane-inner: lane_cnt increments 0..15. On wrap to 0, addr_cnt increments.
  - After beat 256 (lane 15, addr 15), next state is READY, with load_done=1 for exactly that following cycle.
  - in_valid=0 stalls with no counter movement.
  - load_start during LOAD is ignored; the load does not restart.
- READY:
  - bank_ready=1, in_ready=0, busy=0.
  - load_start=1 -> LOAD. Counters are cleared and bank_ready drops the next cycle; old contents are overwritten progressively.
- Reads:
  - wN_rdata is registered: address sampled at edge k, data valid after edge k (1-cycle latency).
  - Lanes are fully independent; identical addresses on different lanes are legal.
  - When state != READY, wN_rdata is driven 0 regardless of raddr.
- Width: data is stored and returned bit-exact, signed; no arithmetic on the data path.
- Reset mid-LOAD: returns to IDLE; partial contents are retained but bank_ready stays 0 until a complete load.
- Simultaneous load_done and load_start (cycle entering READY): load_start takes effect from READY on the next cycle only if still asserted; a pulse coincident with the final beat is ignored.

Optional Feature:
- Macro W_BANK_CHECKSUM_EN.
- Defined:
  - 16-bit checksum register, cleared on load_start acceptance.
  - Each accepted beat adds sign-extended in_data, modulo 2^16.
  - Value is held in READY and reset to 0 by xrst.
- Undefined: checksum port and logic are absent.

Test Plan:
- Reset then idle: xrst low 3 cycles, release, raddr all 0 -> rdata all 0, bank_ready=0, in_ready=0.
- Full load with no stalls: load_start, 256 beats with data = (addr*16+lane) truncated to 8 bits.
  - Expect load_done pulse exactly 1 cycle after the final beat, then bank_ready=1.
  - w7_raddr=3 -> w7_rdata=8'h37 one cycle later.
- Stalled load: in_valid toggles 1/0 each cycle with data = -1 (8'hFF).
  - Expect 512 cycles to load_done.
  - Every lane/address reads -1.
  - With the macro, checksum=16'hFF00 (-256).
- Independent reads: all 16 lanes read different addresses in the same cycle after a known load -> each rdata matches the model with 1-cycle latency. Back-to-back address changes every cycle.
- Reload from READY: load_start -> bank_ready=0 next cycle and reads return 0.
  - Load the pattern inverted; after load_done, w0_raddr=0 returns ~old value.
- Reset mid-load: xrst asserted after beat 100 -> state IDLE, in_ready=0, bank_ready=0.
  - A new full load then completes normally in 256 beats.
